// File: rtl/exec_pkg.sv
// Shared EX-stage definitions: default widths, ALU opcodes and forward-select codes.
// The decode control unit imports the same package, so these encodings are shared.
package exec_pkg;

   localparam int DEF_DATA_W = 18;
   localparam int DEF_PC_W   = 9;
   localparam int DEF_REG_AW = 5;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SHL = 3'b101;
   localparam logic [2:0] ALU_SHR = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Code 2'b11 is unused by the hazard unit and behaves like FWD_REG.
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU for the EX stage; all arithmetic wraps modulo 2^W.
// Shifts use b[4:0]; amounts of W or more naturally shift everything out to zero.
module alu_core
   import exec_pkg::*;
#(
   parameter int W = DEF_DATA_W
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [2:0]   ctrl,
   output logic [W-1:0] result,
   output logic         zero
);

   logic [4:0] shamt;

   assign shamt = b[4:0];

   always_comb begin
      result = '0;
      case (ctrl)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_SHL: result = a << shamt;
         ALU_SHR: result = a >> shamt;
         ALU_SLT: result = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/execute_cycle.sv
// EX stage: operand forwarding, ALU, branch resolution and the EX/MEM pipeline register.
// Branch outputs are combinational so fetch can redirect in the same cycle.
module execute_cycle
   import exec_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int PC_W   = DEF_PC_W,
   parameter int REG_AW = DEF_REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              RegWriteE,
   input  logic              ALUSrcE,
   input  logic              MemWriteE,
   input  logic              ResultSrcE,
   input  logic              BranchE,
   input  logic [2:0]        ALUControlE,
   input  logic [DATA_W-1:0] RD1_E,
   input  logic [DATA_W-1:0] RD2_E,
   input  logic [DATA_W-1:0] Imm_Ext_E,
   input  logic [REG_AW-1:0] RD_E,
   input  logic [PC_W-1:0]   PCE,
   input  logic [PC_W-1:0]   PCPlus4E,
   input  logic [1:0]        RGB_E,
   input  logic [1:0]        ForwardAE,
   input  logic [1:0]        ForwardBE,
   input  logic [DATA_W-1:0] ResultW,
   input  logic              StallM,
   input  logic              FlushM,
   output logic              PCSrcE,
   output logic [PC_W-1:0]   PCTargetE,
   output logic              RegWriteM,
   output logic              MemWriteM,
   output logic              ResultSrcM,
   output logic [DATA_W-1:0] ALUResultM,
   output logic [DATA_W-1:0] WriteDataM,
   output logic [REG_AW-1:0] RD_M,
   output logic [PC_W-1:0]   PCPlus4M,
   output logic [1:0]        RGB_M
);

   logic [DATA_W-1:0] src_a;
   logic [DATA_W-1:0] fwd_b;
   logic [DATA_W-1:0] src_b;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;

   // FWD_MEM reads the live EX/MEM register, which is the held value during a stall.
   always_comb begin
      src_a = RD1_E;
      case (ForwardAE)
         FWD_WB:  src_a = ResultW;
         FWD_MEM: src_a = ALUResultM;
         default: src_a = RD1_E;
      endcase
   end

   always_comb begin
      fwd_b = RD2_E;
      case (ForwardBE)
         FWD_WB:  fwd_b = ResultW;
         FWD_MEM: fwd_b = ALUResultM;
         default: fwd_b = RD2_E;
      endcase
   end

   assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

   alu_core #(
      .W (DATA_W)
   ) u_alu (
      .a      (src_a),
      .b      (src_b),
      .ctrl   (ALUControlE),
      .result (alu_result),
      .zero   (alu_zero)
   );

   assign PCSrcE    = BranchE & alu_zero;
   assign PCTargetE = PCE + Imm_Ext_E[PC_W-1:0];

   // Flush turns the instruction into a bubble by killing only its side-effecting controls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWriteM <= 1'b0;
         MemWriteM <= 1'b0;
      end else if (FlushM) begin
         RegWriteM <= 1'b0;
         MemWriteM <= 1'b0;
      end else if (!StallM) begin
         RegWriteM <= RegWriteE;
         MemWriteM <= MemWriteE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ResultSrcM <= 1'b0;
         ALUResultM <= '0;
         WriteDataM <= '0;
         RD_M       <= '0;
         PCPlus4M   <= '0;
         RGB_M      <= '0;
      end else if (!StallM) begin
         ResultSrcM <= ResultSrcE;
         ALUResultM <= alu_result;
         WriteDataM <= fwd_b;
         RD_M       <= RD_E;
         PCPlus4M   <= PCPlus4E;
         RGB_M      <= RGB_E;
      end
   end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle: a vector table for single-cycle behaviour, then
// hand-written sequences for stall, flush and asynchronous reset.
module tb_execute_cycle;
   import exec_pkg::*;

   logic        clk;
   logic        rst;
   logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
   logic [2:0]  ALUControlE;
   logic [17:0] RD1_E, RD2_E, Imm_Ext_E, ResultW;
   logic [4:0]  RD_E;
   logic [8:0]  PCE, PCPlus4E;
   logic [1:0]  RGB_E, ForwardAE, ForwardBE;
   logic        StallM, FlushM;
   logic        PCSrcE;
   logic [8:0]  PCTargetE;
   logic        RegWriteM, MemWriteM, ResultSrcM;
   logic [17:0] ALUResultM, WriteDataM;
   logic [4:0]  RD_M;
   logic [8:0]  PCPlus4M;
   logic [1:0]  RGB_M;

   int n_total = 0;
   int n_pass  = 0;

   execute_cycle dut (
      .clk         (clk),
      .rst         (rst),
      .RegWriteE   (RegWriteE),
      .ALUSrcE     (ALUSrcE),
      .MemWriteE   (MemWriteE),
      .ResultSrcE  (ResultSrcE),
      .BranchE     (BranchE),
      .ALUControlE (ALUControlE),
      .RD1_E       (RD1_E),
      .RD2_E       (RD2_E),
      .Imm_Ext_E   (Imm_Ext_E),
      .RD_E        (RD_E),
      .PCE         (PCE),
      .PCPlus4E    (PCPlus4E),
      .RGB_E       (RGB_E),
      .ForwardAE   (ForwardAE),
      .ForwardBE   (ForwardBE),
      .ResultW     (ResultW),
      .StallM      (StallM),
      .FlushM      (FlushM),
      .PCSrcE      (PCSrcE),
      .PCTargetE   (PCTargetE),
      .RegWriteM   (RegWriteM),
      .MemWriteM   (MemWriteM),
      .ResultSrcM  (ResultSrcM),
      .ALUResultM  (ALUResultM),
      .WriteDataM  (WriteDataM),
      .RD_M        (RD_M),
      .PCPlus4M    (PCPlus4M),
      .RGB_M       (RGB_M)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ctl packs {RegWrite, MemWrite, ResultSrc}.
   typedef struct {
      logic [2:0]  op;
      logic        alusrc;
      logic        branch;
      logic [1:0]  fa, fb;
      logic [17:0] rd1, rd2, imm, resw;
      logic [8:0]  pce;
      logic [2:0]  ctl;
      logic [4:0]  rd;
      logic [1:0]  rgb;
      logic        e_pcsrc;
      logic [8:0]  e_tgt;
      logic [17:0] e_alu, e_wd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic [2:0] op, logic alusrc, logic branch, logic [1:0] fa,
                               logic [1:0] fb, logic [17:0] rd1, logic [17:0] rd2,
                               logic [17:0] imm, logic [17:0] resw, logic [8:0] pce,
                               logic [2:0] ctl, logic [4:0] rd, logic [1:0] rgb,
                               logic e_pcsrc, logic [8:0] e_tgt, logic [17:0] e_alu,
                               logic [17:0] e_wd);
      vec_t v;
      v.op = op; v.alusrc = alusrc; v.branch = branch; v.fa = fa; v.fb = fb;
      v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.resw = resw; v.pce = pce;
      v.ctl = ctl; v.rd = rd; v.rgb = rgb;
      v.e_pcsrc = e_pcsrc; v.e_tgt = e_tgt; v.e_alu = e_alu; v.e_wd = e_wd;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp)
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic apply(input vec_t v);
      RegWriteE   = v.ctl[2];
      MemWriteE   = v.ctl[1];
      ResultSrcE  = v.ctl[0];
      ALUSrcE     = v.alusrc;
      BranchE     = v.branch;
      ALUControlE = v.op;
      RD1_E       = v.rd1;
      RD2_E       = v.rd2;
      Imm_Ext_E   = v.imm;
      ResultW     = v.resw;
      PCE         = v.pce;
      PCPlus4E    = v.pce + 9'd4;
      RD_E        = v.rd;
      RGB_E       = v.rgb;
      ForwardAE   = v.fa;
      ForwardBE   = v.fb;
   endtask

   task automatic check_regs(input string tag, input logic [2:0] ctl, input logic [17:0] alu,
                             input logic [17:0] wd, input logic [4:0] rd,
                             input logic [8:0] pc4, input logic [1:0] rgb);
      check({tag, "_ctl"}, {29'd0, RegWriteM, MemWriteM, ResultSrcM}, {29'd0, ctl});
      check({tag, "_alu"}, {14'd0, ALUResultM}, {14'd0, alu});
      check({tag, "_wd"},  {14'd0, WriteDataM}, {14'd0, wd});
      check({tag, "_rd"},  {27'd0, RD_M}, {27'd0, rd});
      check({tag, "_pc4"}, {23'd0, PCPlus4M}, {23'd0, pc4});
      check({tag, "_rgb"}, {30'd0, RGB_M}, {30'd0, rgb});
   endtask

   initial begin
      vec_t v;

      //       op       src br fa     fb     rd1       rd2       imm       resw   pce     ctl     rd  rgb pcs tgt     alu       wd
      vecs.push_back(mk(ALU_ADD, 1, 0, 2'b00, 2'b00, 18'h3FFFF, 18'h00123, 18'h1, 18'h0, 9'h000, 3'b100, 1, 1, 0, 9'h001, 18'h0,     18'h00123));
      vecs.push_back(mk(ALU_SUB, 0, 0, 2'b00, 2'b00, 18'h5,     18'h7,     18'h0, 18'h0, 9'h00A, 3'b011, 2, 2, 0, 9'h00A, 18'h3FFFE, 18'h7));
      vecs.push_back(mk(ALU_SLT, 1, 0, 2'b00, 2'b00, 18'h3FFFF, 18'h0,     18'h1, 18'h0, 9'h020, 3'b100, 3, 3, 0, 9'h021, 18'h1,     18'h0));
      vecs.push_back(mk(ALU_SHL, 1, 0, 2'b00, 2'b00, 18'h1,     18'h0,     18'h12, 18'h0, 9'h100, 3'b100, 4, 0, 0, 9'h112, 18'h0,    18'h0));
      vecs.push_back(mk(ALU_SHL, 1, 0, 2'b00, 2'b00, 18'h1,     18'h0,     18'h11, 18'h0, 9'h000, 3'b100, 5, 1, 0, 9'h011, 18'h20000, 18'h0));
      vecs.push_back(mk(ALU_SHR, 1, 0, 2'b00, 2'b00, 18'h20000, 18'h0,     18'h11, 18'h0, 9'h000, 3'b100, 6, 2, 0, 9'h011, 18'h1,    18'h0));
      vecs.push_back(mk(ALU_SHR, 1, 0, 2'b00, 2'b00, 18'h3FFFF, 18'h0,     18'h1F, 18'h0, 9'h000, 3'b100, 7, 3, 0, 9'h01F, 18'h0,    18'h0));
      vecs.push_back(mk(ALU_AND, 0, 0, 2'b00, 2'b00, 18'h0F0F,  18'h00FF,  18'h0, 18'h0, 9'h000, 3'b000, 8, 0, 0, 9'h000, 18'h000F,  18'h00FF));
      vecs.push_back(mk(ALU_OR,  0, 0, 2'b00, 2'b00, 18'h0F0F,  18'h00FF,  18'h0, 18'h0, 9'h000, 3'b000, 9, 0, 0, 9'h000, 18'h0FFF,  18'h00FF));
      vecs.push_back(mk(ALU_XOR, 0, 0, 2'b00, 2'b00, 18'h0F0F,  18'h00FF,  18'h0, 18'h0, 9'h000, 3'b000, 10, 0, 0, 9'h000, 18'h0FF0, 18'h00FF));
      vecs.push_back(mk(ALU_SLT, 0, 0, 2'b00, 2'b00, 18'h1,     18'h3FFFF, 18'h0, 18'h0, 9'h000, 3'b000, 11, 0, 0, 9'h000, 18'h0,    18'h3FFFF));
      vecs.push_back(mk(ALU_SUB, 0, 1, 2'b00, 2'b00, 18'h4,     18'h4,     18'h4, 18'h0, 9'h1FE, 3'b000, 12, 0, 1, 9'h002, 18'h0,    18'h4));
      vecs.push_back(mk(ALU_SUB, 0, 1, 2'b00, 2'b00, 18'h4,     18'h3,     18'h4, 18'h0, 9'h1FE, 3'b000, 13, 0, 0, 9'h002, 18'h1,    18'h3));
      vecs.push_back(mk(ALU_ADD, 1, 0, 2'b00, 2'b00, 18'h9,     18'h0,     18'h0, 18'h0, 9'h000, 3'b100, 14, 0, 0, 9'h000, 18'h9,    18'h0));
      vecs.push_back(mk(ALU_ADD, 1, 0, 2'b10, 2'b00, 18'h5,     18'h0,     18'h0, 18'h7, 9'h000, 3'b100, 15, 0, 0, 9'h000, 18'h9,    18'h0));
      vecs.push_back(mk(ALU_ADD, 1, 0, 2'b01, 2'b00, 18'h5,     18'h0,     18'h0, 18'h7, 9'h000, 3'b100, 16, 0, 0, 9'h000, 18'h7,    18'h0));
      vecs.push_back(mk(ALU_ADD, 1, 0, 2'b11, 2'b00, 18'h5,     18'h0,     18'h0, 18'h7, 9'h000, 3'b100, 17, 0, 0, 9'h000, 18'h5,    18'h0));
      vecs.push_back(mk(ALU_ADD, 1, 0, 2'b00, 2'b10, 18'h2,     18'h100,   18'h0, 18'h0, 9'h000, 3'b010, 18, 0, 0, 9'h000, 18'h2,    18'h5));
      vecs.push_back(mk(ALU_ADD, 1, 0, 2'b00, 2'b01, 18'h3,     18'h100,   18'h0, 18'h7, 9'h000, 3'b010, 19, 0, 0, 9'h000, 18'h3,    18'h7));
      vecs.push_back(mk(ALU_ADD, 1, 0, 2'b00, 2'b00, 18'hA,     18'h0,     18'h14, 18'h0, 9'h000, 3'b100, 1, 0, 0, 9'h014, 18'h1E,  18'h0));
      vecs.push_back(mk(ALU_SUB, 0, 0, 2'b10, 2'b00, 18'h0,     18'h5,     18'h0, 18'h0, 9'h000, 3'b100, 2, 0, 0, 9'h000, 18'h19,    18'h5));
      vecs.push_back(mk(ALU_SUB, 0, 0, 2'b10, 2'b00, 18'h0,     18'h5,     18'h0, 18'h0, 9'h030, 3'b110, 7, 1, 0, 9'h030, 18'h14,    18'h5));

      rst = 1'b0; StallM = 1'b0; FlushM = 1'b0;
      apply(mk(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
      #1;
      check_regs("reset0", 3'b000, 18'h0, 18'h0, 5'd0, 9'h0, 2'd0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         apply(vecs[i]);
         #1;
         check($sformatf("v%0d_pcsrc", i), {31'd0, PCSrcE}, {31'd0, vecs[i].e_pcsrc});
         check($sformatf("v%0d_tgt", i), {23'd0, PCTargetE}, {23'd0, vecs[i].e_tgt});
         @(posedge clk);
         #1;
         check_regs($sformatf("v%0d", i), vecs[i].ctl, vecs[i].e_alu, vecs[i].e_wd,
                    vecs[i].rd, vecs[i].pce + 9'd4, vecs[i].rgb);
      end

      // Stall: registers hold 0x14/5/ctl 110/rd 7/pc4 034/rgb 1; forwarding still sees 0x14.
      v = mk(ALU_SUB, 0, 1, 2'b10, 2'b00, 18'h0, 18'h14, 18'h0, 18'h0, 9'h050, 3'b001, 9, 2, 1, 9'h050, 18'h0, 18'h14);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         StallM = 1'b1;
         apply(v);
         #1;
         check($sformatf("stall%0d_pcsrc", k), {31'd0, PCSrcE}, 32'd1);
         @(posedge clk);
         #1;
         check_regs($sformatf("stall%0d", k), 3'b110, 18'h14, 18'h5, 5'd7, 9'h034, 2'd1);
      end
      @(negedge clk);
      StallM = 1'b0;
      @(posedge clk);
      #1;
      check_regs("unstall", 3'b001, 18'h0, 18'h14, 5'd9, 9'h054, 2'd2);

      @(negedge clk);
      apply(mk(ALU_ADD, 1, 0, 0, 0, 18'h33, 0, 0, 0, 9'h000, 3'b111, 3, 1, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      check("preflush_ctl", {29'd0, RegWriteM, MemWriteM, ResultSrcM}, 32'd7);
      @(negedge clk);
      StallM = 1'b1; FlushM = 1'b1;
      apply(mk(ALU_ADD, 1, 0, 0, 0, 18'h44, 0, 0, 0, 9'h000, 3'b111, 4, 2, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      check("stallflush_rw", {31'd0, RegWriteM}, 32'd0);
      check("stallflush_mw", {31'd0, MemWriteM}, 32'd0);
      check("stallflush_alu", {14'd0, ALUResultM}, 32'h33);
      @(negedge clk);
      StallM = 1'b0;
      @(posedge clk);
      #1;
      check("flush_rw", {31'd0, RegWriteM}, 32'd0);
      check("flush_mw", {31'd0, MemWriteM}, 32'd0);
      @(negedge clk);
      FlushM = 1'b0;
      @(posedge clk);
      #1;
      check_regs("postflush", 3'b111, 18'h44, 18'h0, 5'd4, 9'h004, 2'd2);

      // Asynchronous reset mid-cycle must clear the registers with no clock edge.
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_regs("midreset", 3'b000, 18'h0, 18'h0, 5'd0, 9'h0, 2'd0);
      @(negedge clk);
      rst = 1'b1;
      apply(mk(ALU_ADD, 1, 0, 0, 0, 18'h55, 18'h6, 0, 0, 9'h010, 3'b100, 5, 3, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      check_regs("postreset", 3'b100, 18'h55, 18'h6, 5'd5, 9'h014, 2'd3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
